// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, branch conditions,
// flag bit positions and the decoded control bundle.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NEQ = 3'b000,
    CC_EQ  = 3'b001,
    CC_GT  = 3'b010,
    CC_LT  = 3'b011,
    CC_GTE = 3'b100,
    CC_LTE = 3'b101,
    CC_OVF = 3'b110,
    CC_UNC = 3'b111
  } ccc_e;

  // Positions within the {Z,V,N} flag vector
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [3:0] R0 = 4'h0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       halt;
    logic [2:0] flag_write;
  } ctrl_t;

  // Evaluate a branch condition code against the committed flags
  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flags);
    logic z, v, n;
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    case (ccc_e'(ccc))
      CC_NEQ:  cond_met = !z;
      CC_EQ:   cond_met = z;
      CC_GT:   cond_met = !z && !n;
      CC_LT:   cond_met = n;
      CC_GTE:  cond_met = z || !n;
      CC_LTE:  cond_met = n || z;
      CC_OVF:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two async read ports, one write port,
// R0 hard-wired to zero, writeback data bypassed to same-cycle reads.
module reg_file
  import decode_stage_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_rs_addr,
  input  logic [AW-1:0] i_rt_addr,
  output logic [DW-1:0] o_rs_data,
  output logic [DW-1:0] o_rt_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data
);

  logic [DW-1:0] r_mem [NREG];
  logic          w_wr_ok;

  assign w_wr_ok = i_wr_en && (i_wr_addr != '0);

  // Storage: cleared by reset, written at the clock edge except for R0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read ports with writeback bypass so decode sees the value being written
  always_comb begin
    o_rs_data = r_mem[i_rs_addr];
    o_rt_data = r_mem[i_rt_addr];
    if (w_wr_ok && (i_wr_addr == i_rs_addr)) o_rs_data = i_wr_data;
    if (w_wr_ok && (i_wr_addr == i_rt_addr)) o_rt_data = i_wr_data;
    if (i_rs_addr == '0) o_rs_data = '0;
    if (i_rt_addr == '0) o_rt_data = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction and control decode, hazard/branch unit
// resolving B/BR in decode, and the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] curr_pc_fd,
  input  logic [DW-1:0] next_pc_fd,
  input  logic [DW-1:0] curr_instr_fd,
  input  logic [2:0]    flags_curr,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [3:0]    ex_rd,
  input  logic          ex_flag_write,
  input  logic          mem_reg_write,
  input  logic [3:0]    mem_rd,
  input  logic          wb_wr_en,
  input  logic [3:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          fetch_enable,
  output logic          branch_en,
  output logic [DW-1:0] branch_target,
  output logic          flush_fd,
  output logic [3:0]    opcode_dx,
  output logic [DW-1:0] rs_data_dx,
  output logic [DW-1:0] rt_data_dx,
  output logic [3:0]    rs_dx,
  output logic [3:0]    rt_dx,
  output logic [3:0]    rd_dx,
  output logic [DW-1:0] imm_dx,
  output logic [DW-1:0] next_pc_dx,
  output logic          reg_write_dx,
  output logic          mem_read_dx,
  output logic          mem_write_dx,
  output logic          halt_dx,
  output logic [2:0]    flag_write_dx
);

  opcode_e       w_op;
  logic [3:0]    w_rs_idx, w_rt_idx, w_rd_idx;
  logic          w_use_rs, w_use_rt, w_is_b, w_is_br;
  logic [DW-1:0] w_imm;
  ctrl_t         w_ctrl;
  logic [DW-1:0] w_rs_data, w_rt_data;
  logic          w_load_use, w_br_flag_hz, w_br_reg_hz, w_stall, w_cond;
  logic          w_pc_unused;

  logic [3:0]    r_opcode, r_rs, r_rt, r_rd;
  logic [DW-1:0] r_rs_data, r_rt_data, r_imm, r_next_pc;
  ctrl_t         r_ctrl;

  // The decode-slot PC is only meaningful to fetch; nothing here consumes it
  assign w_pc_unused = ^curr_pc_fd;

  assign w_op = opcode_e'(curr_instr_fd[15:12]);

  // Field extraction, source usage, immediate and control decode
  always_comb begin
    w_rd_idx = curr_instr_fd[11:8];
    w_rs_idx = curr_instr_fd[7:4];
    w_rt_idx = curr_instr_fd[3:0];
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_is_b   = 1'b0;
    w_is_br  = 1'b0;
    w_imm    = '0;
    w_ctrl   = '0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.flag_write = 3'b111;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.flag_write = 3'b100;
      end
      OP_RED, OP_PADDSB: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        w_rt_idx = curr_instr_fd[11:8];
        w_use_rs = 1'b1;
        w_imm    = {{(DW-5){curr_instr_fd[3]}}, curr_instr_fd[3:0], 1'b0};
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        w_rt_idx = curr_instr_fd[11:8];
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_imm    = {{(DW-5){curr_instr_fd[3]}}, curr_instr_fd[3:0], 1'b0};
        w_ctrl.mem_write = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        // Byte loads merge into the old destination value, so rd is also read as rs
        w_rs_idx = curr_instr_fd[11:8];
        w_use_rs = 1'b1;
        w_imm    = {{(DW-8){1'b0}}, curr_instr_fd[7:0]};
        w_ctrl.reg_write = 1'b1;
      end
      OP_B: begin
        w_is_b = 1'b1;
        w_imm  = {{(DW-10){curr_instr_fd[8]}}, curr_instr_fd[8:0], 1'b0};
      end
      OP_BR: begin
        w_is_br  = 1'b1;
        w_use_rs = 1'b1;
      end
      OP_PCS: begin
        w_ctrl.reg_write = 1'b1;
      end
      OP_HLT: begin
        w_ctrl.halt = 1'b1;
      end
      default: ;
    endcase
    if (w_rd_idx == R0) w_ctrl.reg_write = 1'b0;
  end

  reg_file #(
    .DW   (DW),
    .NREG (NREG)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_rs_addr (w_rs_idx),
    .i_rt_addr (w_rt_idx),
    .o_rs_data (w_rs_data),
    .o_rt_data (w_rt_data),
    .i_wr_en   (wb_wr_en),
    .i_wr_addr (wb_rd),
    .i_wr_data (wb_data)
  );

  // Hazard detection and branch resolution; a stall suppresses any redirect
  always_comb begin
    w_load_use   = ex_mem_read && (ex_rd != R0) &&
                   ((w_use_rs && (ex_rd == w_rs_idx)) || (w_use_rt && (ex_rd == w_rt_idx)));
    w_br_flag_hz = (w_is_b || w_is_br) && ex_flag_write;
    w_br_reg_hz  = w_is_br && (w_rs_idx != R0) &&
                   ((ex_reg_write && (ex_rd == w_rs_idx)) || (mem_reg_write && (mem_rd == w_rs_idx)));
    w_stall      = w_load_use || w_br_flag_hz || w_br_reg_hz;
    w_cond       = cond_met(curr_instr_fd[11:9], flags_curr);
    branch_en    = (w_is_b || w_is_br) && w_cond && !w_stall;
    flush_fd     = branch_en;
    fetch_enable = !w_stall;
    branch_target = w_is_br ? w_rs_data : (next_pc_fd + w_imm);
  end

  // ID/EX register: a stall injects an all-zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_stall) begin
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_next_pc <= '0;
      r_ctrl    <= '0;
    end else begin
      r_opcode  <= w_op;
      r_rs      <= w_rs_idx;
      r_rt      <= w_rt_idx;
      r_rd      <= w_rd_idx;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= w_imm;
      r_next_pc <= next_pc_fd;
      r_ctrl    <= w_ctrl;
    end
  end

  assign opcode_dx     = r_opcode;
  assign rs_dx         = r_rs;
  assign rt_dx         = r_rt;
  assign rd_dx         = r_rd;
  assign rs_data_dx    = r_rs_data;
  assign rt_data_dx    = r_rt_data;
  assign imm_dx        = r_imm;
  assign next_pc_dx    = r_next_pc;
  assign reg_write_dx  = r_ctrl.reg_write;
  assign mem_read_dx   = r_ctrl.mem_read;
  assign mem_write_dx  = r_ctrl.mem_write;
  assign halt_dx       = r_ctrl.halt;
  assign flag_write_dx = r_ctrl.flag_write;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] curr_pc_fd, next_pc_fd, curr_instr_fd;
  logic [2:0]  flags_curr;
  logic        ex_reg_write, ex_mem_read, ex_flag_write, mem_reg_write, wb_wr_en;
  logic [3:0]  ex_rd, mem_rd, wb_rd;
  logic [15:0] wb_data;
  logic        fetch_enable, branch_en, flush_fd;
  logic [15:0] branch_target;
  logic [3:0]  opcode_dx, rs_dx, rt_dx, rd_dx;
  logic [15:0] rs_data_dx, rt_data_dx, imm_dx, next_pc_dx;
  logic        reg_write_dx, mem_read_dx, mem_write_dx, halt_dx;
  logic [2:0]  flag_write_dx;

  always #5 clk = ~clk;

  decode_stage #(.DW(16), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .curr_instr_fd(curr_instr_fd),
    .flags_curr(flags_curr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_flag_write(ex_flag_write), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fetch_enable(fetch_enable), .branch_en(branch_en), .branch_target(branch_target),
    .flush_fd(flush_fd), .opcode_dx(opcode_dx), .rs_data_dx(rs_data_dx), .rt_data_dx(rt_data_dx),
    .rs_dx(rs_dx), .rt_dx(rt_dx), .rd_dx(rd_dx), .imm_dx(imm_dx), .next_pc_dx(next_pc_dx),
    .reg_write_dx(reg_write_dx), .mem_read_dx(mem_read_dx), .mem_write_dx(mem_write_dx),
    .halt_dx(halt_dx), .flag_write_dx(flag_write_dx)
  );

  typedef struct packed {
    logic [3:0]  op, rs, rt, rd;
    logic [15:0] rsd, rtd, imm, npc;
    logic        rw, mr, mw, hlt;
    logic [2:0]  fw;
  } dx_t;

  logic [15:0] m_rf [16];
  dx_t         exp_dx;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register read as decode should see it: R0 is zero, WB data visible same cycle
  function automatic logic [15:0] rd_reg(input logic [3:0] r);
    if (r == 4'd0) return 16'h0;
    if (wb_wr_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic taken(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Expected behaviour of decode for the inputs currently applied
  function automatic void model(output logic stall, output logic ben,
                                output logic [15:0] tgt, output dx_t d);
    logic [3:0] op, a, b, c, rs, rt;
    logic       use_rs, use_rt;
    op = curr_instr_fd[15:12]; a = curr_instr_fd[11:8];
    b = curr_instr_fd[7:4];    c = curr_instr_fd[3:0];
    rs = b; rt = c; use_rs = 1'b0; use_rt = 1'b0;
    d = '0;
    d.op = op; d.rd = a; d.npc = next_pc_fd;
    if (op <= 4'd7) begin
      use_rs = 1'b1; use_rt = 1'b1; d.rw = 1'b1;
      if (op == 4'd0 || op == 4'd1) d.fw = 3'b111;
      else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) d.fw = 3'b100;
    end else begin
      case (op)
        4'd8:  begin rt = a; use_rs = 1'b1; d.rw = 1'b1; d.mr = 1'b1;
                     d.imm = 16'(int'($signed(curr_instr_fd[3:0])) * 2); end
        4'd9:  begin rt = a; use_rs = 1'b1; use_rt = 1'b1; d.mw = 1'b1;
                     d.imm = 16'(int'($signed(curr_instr_fd[3:0])) * 2); end
        4'd10, 4'd11: begin rs = a; use_rs = 1'b1; d.rw = 1'b1;
                     d.imm = {8'h00, curr_instr_fd[7:0]}; end
        4'd12: d.imm = 16'(int'($signed(curr_instr_fd[8:0])) * 2);
        4'd13: use_rs = 1'b1;
        4'd14: d.rw = 1'b1;
        default: d.hlt = 1'b1;
      endcase
    end
    if (a == 4'd0) d.rw = 1'b0;
    d.rs = rs; d.rt = rt; d.rsd = rd_reg(rs); d.rtd = rd_reg(rt);
    stall = (ex_mem_read && ex_rd != 4'd0 &&
             ((use_rs && ex_rd == rs) || (use_rt && ex_rd == rt)))
         || ((op == 4'd12 || op == 4'd13) && ex_flag_write)
         || (op == 4'd13 && rs != 4'd0 &&
             ((ex_reg_write && ex_rd == rs) || (mem_reg_write && mem_rd == rs)));
    ben = (op == 4'd12 || op == 4'd13) && taken(curr_instr_fd[11:9], flags_curr) && !stall;
    tgt = (op == 4'd13) ? d.rsd : 16'(next_pc_fd + d.imm);
    if (stall) d = '0;
  endfunction

  // Per-cycle compare at the falling edge, away from the register updates
  task automatic settle();
    logic st, be;
    logic [15:0] tg;
    dx_t m;
    if (rst) begin
      exp_dx = '0;
      for (int unsigned i = 0; i < 16; i++) m_rf[i] = 16'h0;
    end
    @(negedge clk);
    model(st, be, tg, m);
    chk("fetch_enable", 32'(fetch_enable), 32'(!st));
    chk("branch_en", 32'(branch_en), 32'(be));
    chk("flush_fd", 32'(flush_fd), 32'(be));
    if (be) chk("branch_target", 32'(branch_target), 32'(tg));
    chk("opcode_dx", 32'(opcode_dx), 32'(exp_dx.op));
    chk("rs_dx", 32'(rs_dx), 32'(exp_dx.rs));
    chk("rt_dx", 32'(rt_dx), 32'(exp_dx.rt));
    chk("rd_dx", 32'(rd_dx), 32'(exp_dx.rd));
    chk("rs_data_dx", 32'(rs_data_dx), 32'(exp_dx.rsd));
    chk("rt_data_dx", 32'(rt_data_dx), 32'(exp_dx.rtd));
    chk("imm_dx", 32'(imm_dx), 32'(exp_dx.imm));
    chk("next_pc_dx", 32'(next_pc_dx), 32'(exp_dx.npc));
    chk("reg_write_dx", 32'(reg_write_dx), 32'(exp_dx.rw));
    chk("mem_read_dx", 32'(mem_read_dx), 32'(exp_dx.mr));
    chk("mem_write_dx", 32'(mem_write_dx), 32'(exp_dx.mw));
    chk("halt_dx", 32'(halt_dx), 32'(exp_dx.hlt));
    chk("flag_write_dx", 32'(flag_write_dx), 32'(exp_dx.fw));
  endtask

  // Advance the model across the rising edge
  task automatic advance();
    logic st, be;
    logic [15:0] tg;
    dx_t m;
    @(posedge clk);
    if (rst) begin
      exp_dx = '0;
      for (int unsigned i = 0; i < 16; i++) m_rf[i] = 16'h0;
    end else begin
      model(st, be, tg, m);
      exp_dx = m;
      if (wb_wr_en && wb_rd != 4'd0) m_rf[wb_rd] = wb_data;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic set_instr(input logic [15:0] instr, input logic [15:0] pc);
    curr_instr_fd = instr;
    curr_pc_fd    = pc;
    next_pc_fd    = pc + 16'd2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_instr(16'h0000, 16'h0000);
    flags_curr = 3'b000;
    ex_reg_write = 0; ex_mem_read = 0; ex_flag_write = 0; ex_rd = 0;
    mem_reg_write = 0; mem_rd = 0; wb_wr_en = 0; wb_rd = 0; wb_data = 0;
    settle();
    chk("rst_opcode_dx", 32'(opcode_dx), 32'h0);
    chk("rst_reg_write_dx", 32'(reg_write_dx), 32'h0);
    chk("rst_fetch_enable", 32'(fetch_enable), 32'h1);
    advance();
    cyc();
    rst = 1'b0;

    // ADD R3,R1,R2 after preloading R1=5, R2=7
    wb_wr_en = 1; wb_rd = 1; wb_data = 16'd5; cyc();
    wb_rd = 2; wb_data = 16'd7; cyc();
    wb_wr_en = 0; set_instr(16'h0312, 16'h0004); cyc();
    set_instr(16'h0000, 16'h0006);
    settle();
    chk("t1_rs_data", 32'(rs_data_dx), 32'h5);
    chk("t1_rt_data", 32'(rt_data_dx), 32'h7);
    chk("t1_rd", 32'(rd_dx), 32'h3);
    chk("t1_flag_write", 32'(flag_write_dx), 32'h7);
    advance();

    // Load-use: SUB R5,R4,R1 behind LW R4
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4; set_instr(16'h1541, 16'h0008);
    settle(); chk("t2_stall", 32'(fetch_enable), 32'h0); advance();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    settle();
    chk("t2_release", 32'(fetch_enable), 32'h1);
    chk("t2_bubble_rw", 32'(reg_write_dx), 32'h0);
    advance();
    set_instr(16'h0000, 16'h000A);
    settle();
    chk("t2_sub_op", 32'(opcode_dx), 32'h1);
    chk("t2_sub_rd", 32'(rd_dx), 32'h5);
    advance();

    // Load-use boundaries: rt-only match stalls, LW dest field and ex_rd=0 do not
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; set_instr(16'h0513, 16'h0010); cyc();
    set_instr(16'h8310, 16'h0012); cyc();
    ex_rd = 0; set_instr(16'h0500, 16'h0014); cyc();
    ex_mem_read = 0; ex_reg_write = 0;

    // B EQ, imm9=-2, Z=1
    flags_curr = 3'b100; set_instr(16'hC3FE, 16'h000E);
    settle();
    chk("t3_branch_en", 32'(branch_en), 32'h1);
    chk("t3_flush", 32'(flush_fd), 32'h1);
    chk("t3_target", 32'(branch_target), 32'h000C);
    advance();
    ex_flag_write = 1;
    settle();
    chk("t4_branch_en", 32'(branch_en), 32'h0);
    chk("t4_stall", 32'(fetch_enable), 32'h0);
    advance();
    ex_flag_write = 0;
    settle(); chk("t4_resolve", 32'(branch_en), 32'h1); advance();

    // WB bypass into XOR R1,R2,R3, then a write to R0 is ignored
    wb_wr_en = 1; wb_rd = 2; wb_data = 16'hBEEF; set_instr(16'h2123, 16'h0020); cyc();
    wb_rd = 0; wb_data = 16'hFFFF; set_instr(16'h0100, 16'h0022);
    settle(); chk("t5_bypass", 32'(rs_data_dx), 32'hBEEF); advance();
    wb_wr_en = 0; cyc();
    settle(); chk("t5_r0_zero", 32'(rs_data_dx), 32'h0); advance();

    // Memory, byte-load, PCS and halt encodings
    set_instr(16'h862F, 16'h0030); cyc();
    settle(); chk("lw_imm", 32'(imm_dx), 32'hFFFE); chk("lw_mr", 32'(mem_read_dx), 32'h1); advance();
    set_instr(16'h9127, 16'h0032); cyc();
    set_instr(16'hA9A5, 16'h0034); cyc();
    settle(); chk("llb_imm", 32'(imm_dx), 32'h00A5); chk("llb_rs", 32'(rs_dx), 32'h9); advance();
    set_instr(16'hB93C, 16'h0036); cyc();
    set_instr(16'hE700, 16'h0038); cyc();
    set_instr(16'hF000, 16'h003A); cyc();
    settle(); chk("hlt_halt", 32'(halt_dx), 32'h1); chk("hlt_rw", 32'(reg_write_dx), 32'h0); advance();

    // BR always via R2 (BEEF): stalls on MEM and EX writers of R2, then taken
    set_instr(16'hDE20, 16'h0040); mem_reg_write = 1; mem_rd = 2; cyc();
    mem_reg_write = 0; ex_reg_write = 1; ex_rd = 2; cyc();
    ex_reg_write = 0; ex_rd = 0;
    settle(); chk("br_target", 32'(branch_target), 32'hBEEF); advance();

    // Every condition code against every flag combination
    for (int unsigned c = 0; c < 8; c++) begin
      for (int unsigned f = 0; f < 8; f++) begin
        flags_curr = 3'(f);
        set_instr(16'hC004 | 16'(c << 9), 16'h0100);
        cyc();
      end
    end
    flags_curr = 3'b000; set_instr(16'hC004, 16'h0100);
    settle(); chk("b_ne_z0", 32'(branch_target), 32'h010A); advance();

    // Reset asserted mid-cycle during a stall with a valid instruction in ID/EX
    set_instr(16'h0312, 16'h0200); wb_wr_en = 1; wb_rd = 1; wb_data = 16'h1234; cyc();
    wb_wr_en = 0; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 1;
    settle();
    chk("t6_pre_op", 32'(opcode_dx), 32'h0);
    chk("t6_pre_rw", 32'(reg_write_dx), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_async_rw", 32'(reg_write_dx), 32'h0);
    chk("t6_async_rd", 32'(rd_dx), 32'h0);
    chk("t6_async_rs_data", 32'(rs_data_dx), 32'h0);
    advance();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    rst = 1'b0;
    settle(); chk("t6_fetch_enable", 32'(fetch_enable), 32'h1); advance();
    settle(); chk("t6_rf_cleared", 32'(rs_data_dx), 32'h0); advance();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
